bluetooth_decoder: RTL and testbench
====================================

BLUETOOTH_DECODER -- requirements
Module: bluetooth_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000: idle-gap limit in clk cycles while busy (used only with BT_DECODER_TIMEOUT_EN).
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port rx_byte  input  8  ASCII byte from the BLE module UART receiver.
REQ-005 Port rx_valid  input  1  rx_byte is valid this cycle; one byte per asserted cycle.
REQ-006 Port start  input  1  arms decode of one module response.
REQ-007 Port expect_data  input  1  sampled with start: 1 = AT+BLEUARTRX reply (payload line, then status line); 0 = status line only.
REQ-008 Port output_data  output  32  received payload, first byte in [7:0], second in [15:8], and so on.
REQ-009 Port data_len  output  3  payload bytes captured, 0-4.
REQ-010 Port done  output  1  one-cycle pulse at decode completion.
REQ-011 Port ok  output  1  last decode ended with "OK".
REQ-012 Port error  output  1  last decode ended with "ERROR", an unrecognised status line or a timeout.
REQ-013 Port timeout  output  1  last decode ended by the idle-gap timeout.
REQ-014 Port busy  output  1  decode in progress.

Function
REQ-015 States: IDLE, PAYLOAD, STATUS, FINISH.
- Encoding is free.
- busy=1 in every state except IDLE.
REQ-016 IDLE entry conditions:
- IDLE with start=1 -> PAYLOAD if expect_data=1, else STATUS.
- On that edge: clear output_data, data_len, ok, error, timeout and the 5-byte line buffer.
REQ-017 IDLE ignores rx_valid; busy states ignore start.
REQ-018 In PAYLOAD and STATUS, bytes are accepted only on cycles with rx_valid=1.
- LF (8'h0A) is always discarded.
- CR (8'h0D) terminates the current line.
REQ-019 PAYLOAD capture:
- Each non-CR/LF byte is written to byte lane data_len and data_len increments.
- Once data_len=4, further bytes are dropped and data_len saturates at 4.
- A 5-byte shadow buffer of the line is kept for the REQ-020 check.
REQ-020 PAYLOAD on CR:
- If the line was exactly "OK" (2 bytes), clear output_data and data_len, set ok=1 and go to FINISH. This is an empty RX buffer.
- Otherwise go to STATUS.
- An empty line (CR first) goes to STATUS with data_len=0.
REQ-021 STATUS capture:
- Non-CR/LF bytes are stored in the 5-byte line buffer.
- Line length is counted, saturating at 6.
REQ-022 STATUS on CR, go to FINISH with:
- ok=1 if the line is exactly "OK";
- error=1 if the line is exactly "ERROR";
- error=1 otherwise, including an empty line or more than 5 bytes.
REQ-023 FINISH:
- done=1 for exactly one cycle, then IDLE.
- done is high in the cycle immediately after the edge that sampled the terminating CR.
REQ-024 Hold rules:
- ok, error, timeout, output_data and data_len hold their values from FINISH until the next accepted start.
- ok and error are never both 1.
REQ-025 A start and rx_valid in the same IDLE cycle: start is taken, the byte is discarded.

Reset
REQ-026 Reset forces IDLE and clears output_data, data_len, done, ok, error, timeout, busy, the line buffer and the timeout counter immediately, regardless of clk.
REQ-027 Reset asserted mid-decode aborts the decode with no done pulse.
- The first start after reset deasserts begins a fresh decode.

Configuration
REQ-028 Macro BT_DECODER_TIMEOUT_EN defined, in PAYLOAD or STATUS:
- A counter clears on every rx_valid cycle and on state entry, and increments otherwise.
- On reaching TIMEOUT_CYCLES: go to FINISH with timeout=1, error=1, ok=0; captured payload retained.
REQ-029 Macro BT_DECODER_TIMEOUT_EN undefined:
- No counter is built and timeout is tied to 0.
- The decoder waits indefinitely for CR.

Verification
REQ-030 Status only: start, expect_data=0; stream "OK\r\n" -> done pulse one cycle after CR; ok=1, error=0, data_len=0.
REQ-031 Error status: start, expect_data=0; stream "ERROR\r\n" -> ok=0, error=1; gapped rx_valid gives the same result.
REQ-032 Payload: start, expect_data=1; stream "Hi!\r\nOK\r\n" -> output_data=32'h00216948, data_len=3, ok=1.
REQ-033 Long payload and empty buffer:
- "ABCDEF\r\nOK\r\n" -> output_data=32'h44434241, data_len=4.
- "OK\r\n" alone -> data_len=0, ok=1, a single done pulse.
REQ-034 Reset and timeout:
- Reset asserted after "AB" of a payload -> all outputs 0 immediately, no done pulse.
- With BT_DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=100, a 100-cycle gap -> timeout=1, error=1.
REQ-035 Junk status: "OKAY\r" -> error=1; start pulses while busy are ignored; bytes while idle leave every output unchanged.

Source files
------------

// File: rtl/bluetooth_decoder.sv
// rtl/bluetooth_decoder.sv - decodes BLE UART module replies (payload line and OK/ERROR status line)
// Optional idle-gap timeout enabled by defining BT_DECODER_TIMEOUT_EN.
module bluetooth_decoder #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   input  logic        start,
   input  logic        expect_data,
   output logic [31:0] output_data,
   output logic [2:0]  data_len,
   output logic        done,
   output logic        ok,
   output logic        error,
   output logic        timeout,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, PAYLOAD, STATUS, FINISH} state_t;

   state_t          state, next_state;
   logic [4:0][7:0] line_buf;
   logic [2:0]      line_len;
   logic            in_line, is_cr, is_data, line_is_ok, line_is_error, tmo;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   assign in_line       = (state == PAYLOAD) || (state == STATUS);
   assign is_cr         = in_line && rx_valid && (rx_byte == 8'h0D);
   assign is_data       = in_line && rx_valid && (rx_byte != 8'h0D) && (rx_byte != 8'h0A);
   assign line_is_ok    = (line_len == 3'd2) && (line_buf[0] == 8'h4F) && (line_buf[1] == 8'h4B);
   assign line_is_error = (line_len == 3'd5) &&
                          ({line_buf[0], line_buf[1], line_buf[2], line_buf[3], line_buf[4]} == "ERROR");
   assign done          = (state == FINISH);
   assign busy          = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = expect_data ? PAYLOAD : STATUS;
         PAYLOAD: begin
            // A bare "OK" as the first line means the module's RX buffer was empty.
            if (is_cr)    next_state = line_is_ok ? FINISH : STATUS;
            else if (tmo) next_state = FINISH;
         end
         STATUS:  if (is_cr || tmo) next_state = FINISH;
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         output_data <= '0;
         data_len    <= '0;
         ok          <= 1'b0;
         error       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               output_data <= '0;
               data_len    <= '0;
               ok          <= 1'b0;
               error       <= 1'b0;
            end
            PAYLOAD: begin
               if (is_data && (data_len != 3'd4)) begin
                  output_data[{data_len[1:0], 3'b000} +: 8] <= rx_byte;
                  data_len <= data_len + 3'd1;
               end
               if (is_cr && line_is_ok) begin
                  output_data <= '0;
                  data_len    <= '0;
                  ok          <= 1'b1;
               end
               if (tmo) begin
                  ok    <= 1'b0;
                  error <= 1'b1;
               end
            end
            STATUS: begin
               if (is_cr) begin
                  ok    <= line_is_ok;
                  error <= !line_is_ok || line_is_error;
               end
               if (tmo) begin
                  ok    <= 1'b0;
                  error <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // The line buffer restarts for the status line after a non-OK payload line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_buf <= '0;
         line_len <= '0;
      end else if (((state == IDLE) && start) || ((state == PAYLOAD) && is_cr)) begin
         line_buf <= '0;
         line_len <= '0;
      end else if (is_data) begin
         if (line_len < 3'd5) line_buf[line_len] <= rx_byte;
         if (line_len != 3'd6) line_len <= line_len + 3'd1;
      end
   end

`ifdef BT_DECODER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] idle_count;

   assign tmo = in_line && !rx_valid && (idle_count == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                         idle_count <= '0;
      else if (!in_line || rx_valid || (next_state != state)) idle_count <= '0;
      else                                               idle_count <= idle_count + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        timeout <= 1'b0;
      else if ((state == IDLE) && start) timeout <= 1'b0;
      else if (tmo)                     timeout <= 1'b1;
   end
`else
   assign tmo     = 1'b0;
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bluetooth_decoder.sv
// tb/tb_bluetooth_decoder.sv - randomized self-checking bench for bluetooth_decoder against a line-level model
module tb_bluetooth_decoder;

`ifdef BT_DECODER_TIMEOUT_EN
   localparam int TO = 100;
`else
   localparam int TO = 50000;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_byte = '0;
   logic        rx_valid = 1'b0;
   logic        start = 1'b0;
   logic        expect_data = 1'b0;
   logic [31:0] output_data;
   logic [2:0]  data_len;
   logic        done, ok, error, timeout, busy;

   int tests = 0;
   int fails = 0;

   logic [31:0] last_d;
   logic [2:0]  last_len;
   bit          last_ok, last_err;

   always #5 clk = ~clk;

   bluetooth_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .start(start), .expect_data(expect_data), .output_data(output_data),
      .data_len(data_len), .done(done), .ok(ok), .error(error),
      .timeout(timeout), .busy(busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // '|' stands for CR and '~' for LF in readable stream literals.
   function automatic string enc(input string t);
      string r;
      r = t;
      for (int i = 0; i < r.len(); i++) begin
         if (r[i] == 8'h7C) r[i] = 8'h0D;
         else if (r[i] == 8'h7E) r[i] = 8'h0A;
      end
      return r;
   endfunction

   function automatic bit line_eq(input byte q[$], input string t);
      if (q.size() != t.len()) return 1'b0;
      for (int i = 0; i < q.size(); i++) if (q[i] != t[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model(input string s, input bit ed, output logic [31:0] d,
                                 output logic [2:0] len, output bit mok, output bit merr,
                                 output int term);
      byte line[$];
      bit  status_phase;
      status_phase = !ed;
      d = '0; len = '0; mok = 0; merr = 0; term = -1;
      for (int i = 0; i < s.len() && term < 0; i++) begin
         byte c;
         c = s[i];
         if (c == 8'h0A) continue;
         if (c != 8'h0D) begin
            line.push_back(c);
            continue;
         end
         if (!status_phase) begin
            if (line_eq(line, "OK")) begin
               mok = 1; term = i;
            end else begin
               for (int k = 0; k < line.size() && k < 4; k++) d[8*k +: 8] = line[k];
               len = (line.size() > 4) ? 3'd4 : 3'(line.size());
               status_phase = 1;
               line.delete();
            end
         end else begin
            mok = line_eq(line, "OK");
            merr = !mok;
            term = i;
         end
      end
   endfunction

   task automatic run_decode(input string name, input string raw, input bit ed,
                             input int gap_max, input bit noise);
      string       s;
      logic [31:0] ed_d;
      logic [2:0]  ed_len;
      bit          e_ok, e_err;
      int          term, done_cnt, done_idx;
      s = enc(raw);
      model(s, ed, ed_d, ed_len, e_ok, e_err, term);
      done_cnt = 0; done_idx = -1;
      start = 1; expect_data = ed; rx_valid = 0;
      step();
      start = 0;
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
      for (int i = 0; i < s.len(); i++) begin
         int g;
         g = $urandom_range(0, gap_max);
         for (int k = 0; k < g; k++) begin
            rx_valid = 0; rx_byte = 8'($urandom);
            start = (noise && i <= term) ? 1'($urandom_range(0, 1)) : 1'b0;
            expect_data = 1'($urandom);
            step();
            start = 0;
            if (done) begin done_cnt++; done_idx = -2; end
         end
         rx_valid = 1; rx_byte = s[i];
         step();
         if (done) begin done_cnt++; done_idx = i; end
      end
      rx_valid = 0;
      step();
      if (done) done_cnt++;
      step();
      if (done) done_cnt++;
      tests++;
      if (done_cnt !== 1 || done_idx !== term) begin
         fails++;
         $display("FAIL %s done_pulse: got count %0d at byte %0d want count 1 at byte %0d", name, done_cnt, done_idx, term);
      end
      tests++;
      if (output_data !== ed_d || data_len !== ed_len) begin
         fails++;
         $display("FAIL %s data: got %h/%0d want %h/%0d", name, output_data, data_len, ed_d, ed_len);
      end
      tests++;
      if (ok !== e_ok || error !== e_err || timeout !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL %s status: got ok=%b err=%b to=%b busy=%b want ok=%b err=%b to=0 busy=0",
                  name, ok, error, timeout, busy, e_ok, e_err);
      end
      last_d = ed_d; last_len = ed_len; last_ok = e_ok; last_err = e_err;
   endtask

   task automatic test_reset();
      reset = 1;
      step();
      tests++;
      if ({output_data, data_len, done, ok, error, timeout, busy} !== '0) begin
         fails++;
         $display("FAIL reset_state: got data=%h len=%0d d=%b ok=%b err=%b to=%b busy=%b want all 0",
                  output_data, data_len, done, ok, error, timeout, busy);
      end
      reset = 0;
      step();
   endtask

   task automatic test_directed();
      run_decode("status_ok", "OK|~", 0, 0, 0);
      run_decode("status_error", "ERROR|~", 0, 0, 0);
      run_decode("status_error_gapped", "ERROR|~", 0, 4, 0);
      run_decode("payload_hi", "Hi!|~OK|~", 1, 0, 0);
      tests++;
      if (output_data !== 32'h00216948) begin
         fails++; $display("FAIL payload_hi_const: got %h want 00216948", output_data);
      end
      run_decode("payload_long", "ABCDEF|~OK|~", 1, 1, 0);
      tests++;
      if (output_data !== 32'h44434241 || data_len !== 3'd4) begin
         fails++; $display("FAIL payload_long_const: got %h/%0d want 44434241/4", output_data, data_len);
      end
      run_decode("empty_buffer", "OK|~", 1, 0, 0);
      run_decode("empty_line", "|~OK|~", 1, 0, 0);
      run_decode("junk_status", "OKAY|", 0, 0, 0);
      run_decode("long_status", "ERRORS|~", 0, 0, 0);
   endtask

   task automatic test_busy_start();
      run_decode("busy_start_ignored", "AB|~OKAY|~", 1, 3, 1);
   endtask

   task automatic test_idle_bytes();
      for (int k = 0; k < 12; k++) begin
         rx_valid = 1;
         rx_byte = (k % 4 == 3) ? 8'h0D : 8'($urandom);
         step();
         tests++;
         if (output_data !== last_d || data_len !== last_len || ok !== last_ok ||
             error !== last_err || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_bytes: got %h/%0d ok=%b err=%b d=%b busy=%b want %h/%0d ok=%b err=%b d=0 busy=0",
                     output_data, data_len, ok, error, done, busy, last_d, last_len, last_ok, last_err);
         end
      end
      rx_valid = 0;
   endtask

   task automatic test_same_cycle();
      start = 1; expect_data = 1; rx_valid = 1; rx_byte = "X";
      step();
      start = 0; rx_valid = 0;
      step();
      rx_valid = 1; rx_byte = "O"; step();
      rx_byte = "K"; step();
      rx_byte = 8'h0D; step();
      tests++;
      if (done !== 1'b1 || ok !== 1'b1 || data_len !== 3'd0) begin
         fails++;
         $display("FAIL start_with_byte: got done=%b ok=%b len=%0d want done=1 ok=1 len=0", done, ok, data_len);
      end
      rx_byte = 8'h0A; step();
      rx_valid = 0;
      step();
   endtask

   task automatic test_reset_mid();
      int dc;
      start = 1; expect_data = 1;
      step();
      start = 0;
      rx_valid = 1; rx_byte = "A"; step();
      rx_byte = "B"; step();
      rx_valid = 0;
      #2;
      reset = 1;
      #1;
      tests++;
      if ({output_data, data_len, done, ok, error, timeout, busy} !== '0) begin
         fails++;
         $display("FAIL reset_mid_decode: got data=%h len=%0d d=%b ok=%b err=%b to=%b busy=%b want all 0",
                  output_data, data_len, done, ok, error, timeout, busy);
      end
      step();
      reset = 0;
      dc = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (done || busy) dc++;
      end
      tests++;
      if (dc !== 0) begin fails++; $display("FAIL reset_no_done: got %0d active cycles want 0", dc); end
      run_decode("after_reset", "OK|~", 0, 0, 0);
   endtask

   task automatic test_random();
      string sts[7] = '{"OK", "ERROR", "OKAY", "", "ERR", "OKOK", "ERRORS"};
      for (int n = 0; n < 40; n++) begin
         string pay, raw;
         int    plen;
         bit    ed;
         ed = 1'($urandom);
         plen = $urandom_range(0, 6);
         pay = "......";
         for (int k = 0; k < 6; k++) pay[k] = 8'($urandom_range(65, 90));
         pay = (plen == 0) ? "" : pay.substr(0, plen - 1);
         if ($urandom_range(0, 4) == 0) pay = "OK";
         raw = ed ? {pay, "|~", sts[$urandom_range(0, 6)], "|~"} : {sts[$urandom_range(0, 6)], "|~"};
         run_decode($sformatf("random_%0d", n), raw, ed, $urandom_range(0, 3), 1'($urandom));
      end
   endtask

`ifdef BT_DECODER_TIMEOUT_EN
   task automatic test_timeout();
      int wait_cycles;
      start = 1; expect_data = 1;
      step();
      start = 0;
      rx_valid = 1; rx_byte = "A"; step();
      rx_valid = 0;
      wait_cycles = 0;
      while (!done && wait_cycles < 150) begin
         step();
         wait_cycles++;
      end
      tests++;
      if (wait_cycles !== TO || timeout !== 1'b1 || error !== 1'b1 || ok !== 1'b0 ||
          output_data !== 32'h41 || data_len !== 3'd1) begin
         fails++;
         $display("FAIL timeout: got gap=%0d to=%b err=%b ok=%b data=%h/%0d want gap=%0d to=1 err=1 ok=0 data=00000041/1",
                  wait_cycles, timeout, error, ok, output_data, data_len, TO);
      end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_idle_bytes();
      test_busy_start();
      test_same_cycle();
      test_reset_mid();
      test_random();
`ifdef BT_DECODER_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
